// File: rtl/icache_defs.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// derived address-field widths and the refill FSM state encoding.
package icache_defs;

    localparam int DEF_INDEX_WIDTH    = 6;
    localparam int DEF_LINE_WORDS_LOG = 2;

    localparam int OFF        = DEF_LINE_WORDS_LOG + 2;
    localparam int TAG_WIDTH  = 32 - OFF - DEF_INDEX_WIDTH;
    localparam int LINE_WORDS = 1 << DEF_LINE_WORDS_LOG;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage for the instruction cache: combinational read port,
// whole-line write port, valid bits cleared by synchronous reset.
module icache_line_array
    import icache_defs::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int TAG_W       = TAG_WIDTH,
    parameter int WORDS       = LINE_WORDS,
    localparam int WORDS_LOG  = $clog2(WORDS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    input  logic [WORDS_LOG-1:0]   rd_word,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [31:0]            rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic [WORDS*32-1:0]    wr_line
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tags and data need no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
            for (int w = 0; w < WORDS; w++) begin
                data_q[wr_index][w] <= wr_line[w*32 +: 32];
            end
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with word-by-word line refill.
// Optional macro ICACHE_EARLY_HIT_EN forwards refill words to the fetch port.
module icache
    import icache_defs::*;
#(
    parameter int INDEX_WIDTH    = DEF_INDEX_WIDTH,
    parameter int LINE_WORDS_LOG = DEF_LINE_WORDS_LOG
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic [31:0] fetchIn,
    output logic        hit,
    output logic [31:0] icacheOut,
    output logic        memReqOut,
    output logic [31:0] memAddrOut,
    input  logic        memValidIn,
    input  logic [31:0] memDataIn
);

    localparam int LOFF   = LINE_WORDS_LOG + 2;
    localparam int LTAG   = 32 - LOFF - INDEX_WIDTH;
    localparam int LWORDS = 1 << LINE_WORDS_LOG;
    localparam logic [LINE_WORDS_LOG-1:0] LAST = '1;

    state_t                    state;
    logic [LINE_WORDS_LOG-1:0] counter;
    logic [31:0]               fill_q [LWORDS];

    logic [LTAG-1:0]           tag_f;
    logic [INDEX_WIDTH-1:0]    index_f;
    logic [LINE_WORDS_LOG-1:0] word_f;
    logic                      unused_byte;

    logic                      rd_valid;
    logic [LTAG-1:0]           rd_tag;
    logic [31:0]               rd_data;
    logic                      base_hit;
    logic [31:0]               word_sel;

    logic                      wr_en;
    logic [LWORDS*32-1:0]      wr_line;

    assign tag_f       = fetchIn[31:LOFF+INDEX_WIDTH];
    assign index_f     = fetchIn[LOFF+INDEX_WIDTH-1:LOFF];
    assign word_f      = fetchIn[LOFF-1:2];
    assign unused_byte = ^fetchIn[1:0];

    icache_line_array #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .TAG_W      (LTAG),
        .WORDS      (LWORDS)
    ) u_lines (
        .clock   (clockIn),
        .reset   (resetIn),
        .rd_index(index_f),
        .rd_word (word_f),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_index(memAddrOut[LOFF+INDEX_WIDTH-1:LOFF]),
        .wr_tag  (memAddrOut[31:LOFF+INDEX_WIDTH]),
        .wr_line (wr_line)
    );

    assign base_hit = rd_valid && (rd_tag == tag_f);

    // The last word goes straight from the bus into the committed line.
    assign wr_en = readyIn && (state == REFILL) && memValidIn && (counter == LAST);

    always_comb begin
        wr_line = '0;
        for (int w = 0; w < LWORDS; w++) begin
            wr_line[w*32 +: 32] = (w == LWORDS - 1) ? memDataIn : fill_q[w];
        end
    end

`ifdef ICACHE_EARLY_HIT_EN
    logic in_line;
    assign in_line = (state == REFILL) && (fetchIn[31:LOFF] == memAddrOut[31:LOFF]);

    always_comb begin
        hit      = base_hit;
        word_sel = rd_data;
        if (in_line) begin
            if (memValidIn && (word_f == counter)) begin
                hit      = 1'b1;
                word_sel = memDataIn;
            end else if (word_f < counter) begin
                hit      = 1'b1;
                word_sel = fill_q[word_f];
            end
        end
    end
`else
    assign hit      = base_hit;
    assign word_sel = rd_data;
`endif

    assign icacheOut = hit ? word_sel : 32'h0;

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state      <= IDLE;
            counter    <= '0;
            memReqOut  <= 1'b0;
            memAddrOut <= '0;
        end else if (readyIn) begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        state      <= REFILL;
                        counter    <= '0;
                        memReqOut  <= 1'b1;
                        memAddrOut <= {fetchIn[31:LOFF], {LOFF{1'b0}}};
                    end
                end
                REFILL: begin
                    if (memValidIn) begin
                        fill_q[counter] <= memDataIn;
                        counter         <= counter + 1'b1;
                        if (counter == LAST) begin
                            state     <= IDLE;
                            memReqOut <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, eviction, hit under
// refill, stall, reset mid-refill, early hit and address wrap.
module tb_icache;

    logic        clockIn;
    logic        resetIn;
    logic        readyIn;
    logic [31:0] fetchIn;
    logic        hit;
    logic [31:0] icacheOut;
    logic        memReqOut;
    logic [31:0] memAddrOut;
    logic        memValidIn;
    logic [31:0] memDataIn;

    int checks;
    int failures;

    icache dut (
        .clockIn   (clockIn),
        .resetIn   (resetIn),
        .readyIn   (readyIn),
        .fetchIn   (fetchIn),
        .hit       (hit),
        .icacheOut (icacheOut),
        .memReqOut (memReqOut),
        .memAddrOut(memAddrOut),
        .memValidIn(memValidIn),
        .memDataIn (memDataIn)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        memValidIn = 1'b1;
        memDataIn  = word;
        tick();
        memValidIn = 1'b0;
        memDataIn  = 32'h0;
    endtask

    task automatic probe(input string tag, input logic [31:0] addr, input logic exp_hit, input logic [31:0] exp_word);
        fetchIn = addr;
        #1;
        checkOutput({tag, "_hit"}, {31'b0, hit}, {31'b0, exp_hit});
        checkOutput({tag, "_data"}, icacheOut, exp_word);
    endtask

    logic exp_early;

    initial begin
        checks     = 0;
        failures   = 0;
        resetIn    = 1'b1;
        readyIn    = 1'b1;
        fetchIn    = 32'h0;
        memValidIn = 1'b0;
        memDataIn  = 32'h0;
`ifdef ICACHE_EARLY_HIT_EN
        exp_early = 1'b1;
`else
        exp_early = 1'b0;
`endif
        tick();
        tick();
        resetIn = 1'b0;
        #1;
        checkOutput("reset_hit", {31'b0, hit}, 32'h0);
        checkOutput("reset_req", {31'b0, memReqOut}, 32'h0);
        checkOutput("reset_addr", memAddrOut, 32'h0);

        // cold miss on line 0x000
        tick();
        checkOutput("cold_req", {31'b0, memReqOut}, 32'h1);
        checkOutput("cold_addr", memAddrOut, 32'h0);
        applyStimulus(32'h11);
        applyStimulus(32'h22);
        applyStimulus(32'h33);
        applyStimulus(32'h44);
        checkOutput("cold_req_drop", {31'b0, memReqOut}, 32'h0);
        probe("cold_w0", 32'h0, 1'b1, 32'h11);
        probe("cold_w3", 32'hC, 1'b1, 32'h44);
        tick();
        checkOutput("cold_no_req", {31'b0, memReqOut}, 32'h0);

        // fill line 0x010 for the hit-under-refill case
        probe("l10_miss", 32'h10, 1'b0, 32'h0);
        tick();
        checkOutput("l10_addr", memAddrOut, 32'h10);
        applyStimulus(32'h1010);
        applyStimulus(32'h1014);
        applyStimulus(32'h1018);
        applyStimulus(32'h101C);

        // conflict eviction: 0x400 maps onto index 0
        probe("conf_miss", 32'h400, 1'b0, 32'h0);
        tick();
        checkOutput("conf_req", {31'b0, memReqOut}, 32'h1);
        checkOutput("conf_addr", memAddrOut, 32'h400);
        applyStimulus(32'hA0);
        applyStimulus(32'hA1);
        probe("hur", 32'h14, 1'b1, 32'h1014);

        // stall with a stray valid pulse that must be dropped
        readyIn    = 1'b0;
        memValidIn = 1'b1;
        memDataIn  = 32'hDEAD;
        tick();
        tick();
        tick();
        memValidIn = 1'b0;
        readyIn    = 1'b1;
        checkOutput("stall_req", {31'b0, memReqOut}, 32'h1);
        checkOutput("stall_addr", memAddrOut, 32'h400);

        // early hit on word 2 while it arrives
        memValidIn = 1'b1;
        memDataIn  = 32'hABCD;
        fetchIn    = 32'h408;
        #1;
        checkOutput("early_hit", {31'b0, hit}, {31'b0, exp_early});
        checkOutput("early_data", icacheOut, exp_early ? 32'hABCD : 32'h0);
        tick();
        memValidIn = 1'b0;
        checkOutput("pre_last_req", {31'b0, memReqOut}, 32'h1);
        applyStimulus(32'hA3);
        checkOutput("conf_req_drop", {31'b0, memReqOut}, 32'h0);
        probe("conf_w2", 32'h408, 1'b1, 32'hABCD);
        probe("conf_w1", 32'h404, 1'b1, 32'hA1);
        probe("conf_w3", 32'h40C, 1'b1, 32'hA3);
        probe("evicted", 32'h0, 1'b0, 32'h0);
        probe("conf_w0", 32'h400, 1'b1, 32'hA0);
        probe("l10_still", 32'h18, 1'b1, 32'h1018);

        // reset in the middle of a refill
        probe("rst_miss", 32'h800, 1'b0, 32'h0);
        tick();
        checkOutput("rst_req", {31'b0, memReqOut}, 32'h1);
        applyStimulus(32'h80);
        applyStimulus(32'h81);
        resetIn = 1'b1;
        tick();
        resetIn = 1'b0;
        checkOutput("rst_req_drop", {31'b0, memReqOut}, 32'h0);
        checkOutput("rst_addr", memAddrOut, 32'h0);
        probe("rst_l10", 32'h10, 1'b0, 32'h0);

        // wrap at the top of the address space
        probe("wrap_miss", 32'hFFFFFFF4, 1'b0, 32'h0);
        tick();
        checkOutput("wrap_addr", memAddrOut, 32'hFFFFFFF0);
        applyStimulus(32'hF0);
        applyStimulus(32'hF4);
        applyStimulus(32'hF8);
        applyStimulus(32'hFC);
        probe("wrap_w3", 32'hFFFFFFFC, 1'b1, 32'hFC);
        probe("wrap_w0", 32'hFFFFFFF0, 1'b1, 32'hF0);
        checkOutput("wrap_req", {31'b0, memReqOut}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the instruction fetch unit and the memory controller. Answers a fetch address combinationally in the same cycle (`hit` plus instruction word). On a miss it refills one whole line from the memory controller, word by word, then returns to lookup. It has no write path and is never flushed except by reset.

## Interface
- `INDEX_WIDTH`, default 6: line index bits, giving 64 lines.
- `LINE_WORDS_LOG`, default 2: log2 of 32-bit words per line, giving 4 words (16 B).
- `clockIn`  in  1  system clock; all state updates on the rising edge.
- `resetIn`  in  1  reset, synchronous and active-high.
- `readyIn`  in  1  global enable; when low, all state is frozen.
- `fetchIn`  in  32  fetch byte address; bits [1:0] are ignored.
- `hit`  out  1  combinational: the `fetchIn` word is present.
- `icacheOut`  out  32  instruction word; valid only while `hit`=1, otherwise 0.
- `memReqOut`  out  1  line refill request, held high until the last word is accepted.
- `memAddrOut`  out  32  line base address, with the offset bits zero.
- `memValidIn`  in  1  one refill word is present on `memDataIn` this cycle.
- `memDataIn`  in  32  refill word; words arrive in ascending address order.

## Operation
- Address split:
  - offset = [OFF-1:0], where OFF = LINE_WORDS_LOG+2.
  - index = [OFF+INDEX_WIDTH-1:OFF].
  - tag = [31:OFF+INDEX_WIDTH].
- Per-line storage: valid bit, tag, and LINE_WORDS×32 data.
- Lookup: `hit` = valid[index] & (tag[index]==tag(fetchIn)), evaluated in every state. Hit-under-refill to other lines is permitted.
- FSM states:
  - IDLE → REFILL when `readyIn` & ~`hit`. Latch line base of `fetchIn` into `memAddrOut`, clear word counter, raise `memReqOut`.
  - REFILL: on each `readyIn` & `memValidIn`, write `memDataIn` into fill buffer[counter] and increment counter.
  - REFILL → IDLE on acceptance of word LINE_WORDS-1. On that edge commit the fill buffer, tag and valid=1 to the latched index, and drop `memReqOut`.
- A partially filled line is never visible: valid is set only on commit, in the base build.
- While in REFILL, changes to `fetchIn` do not alter the refill in progress.
- The refill is never aborted, except by reset.
- `memValidIn` is ignored in IDLE.
- Commit overwrites any previous tag at that index (no replacement choice).

## Timing
- Hit latency: 0 cycles (combinational from `fetchIn`).
- Miss to request: `memReqOut` goes high on the edge following the miss cycle.
- Commit to hit: the committed line hits in the cycle after the last word edge.
- Back-to-back misses: one IDLE cycle occurs between consecutive refills.
- `readyIn`=0: FSM, counter, arrays and outputs are held. A `memValidIn` pulse in such a cycle is dropped; the memory controller never issues one.
- Reset, also mid-refill: on the next edge all valid bits = 0, state = IDLE, counter = 0, `memReqOut` = 0, `memAddrOut` = 0. `hit` = 0 from then on until the first commit.
- Address wrap: a line at 0xFFFFFFF0 refills normally; the counter does not carry into the tag.

## Configuration
- `ICACHE_EARLY_HIT_EN` defined:
  - During REFILL, `hit`=1 and `icacheOut`=`memDataIn` in any cycle where `memValidIn`=1, `fetchIn` lies in the refilling line, and the word offset equals the counter.
  - Words already written to the fill buffer for that line also hit.
- Undefined: no forwarding; only committed lines hit.

## Structure
- Shared header `icache_defs`: OFF, TAG_WIDTH and LINE_WORDS localparams, plus the IDLE/REFILL state encodings.
- Sub-module `icache_line_array` holds storage:
  - combinational read port for tag/valid/word;
  - one-line write port;
  - synchronous valid clear on reset.
- FSM, fill buffer and forwarding logic stay in `icache`.

## Test plan
- Cold miss:
  - Stimulus: reset, `fetchIn`=0x00000000; memory returns 0x11,0x22,0x33,0x44 on 4 consecutive cycles.
  - Required: `memReqOut`=1 with `memAddrOut`=0x0. Next cycle after the last word, `hit`=1 and `icacheOut`=0x11. `fetchIn`=0xC then gives 0x44 with no request.
- Conflict eviction:
  - Stimulus: fill 0x000, then fetch 0x400, which has the same index in the 64×16 B config.
  - Required: new refill at `memAddrOut`=0x400. Afterwards 0x000 misses and 0x400 hits.
- Hit under refill:
  - Stimulus: during refill of 0x400, drive `fetchIn`=0x010 (cached).
  - Required: `hit`=1 with the correct data. The refill of 0x400 completes unaffected.
- Stall:
  - Stimulus: `readyIn`=0 for 3 cycles mid-refill.
  - Required: counter and `memReqOut` unchanged. Completion is delayed by exactly 3 cycles.
- Reset mid-refill:
  - Stimulus: assert `resetIn` after 2 words.
  - Required: `memReqOut`=0 next cycle. Previously valid lines now miss.
- Early hit (macro on):
  - Stimulus: `fetchIn`=0x408 while word 2 of line 0x400 arrives with 0xABCD.
  - Required: `hit`=1 and `icacheOut`=0xABCD in that same cycle. With the macro off, `hit`=0.
